// File: rtl/control_unit.sv
// Hardwired Moore sequencer driving the datapath register-transfer strobes.
// Optional macro CU_MEM_WAIT_EN: T1 stalls until mem_ready is high.
module control_unit #(
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic               stop,
    input  logic               mem_ready,
    input  logic [31:0]        ir,
    output logic               PCout,
    output logic               PCin,
    output logic               IncPc,
    output logic               MARin,
    output logic               Zin,
    output logic               Zlowout,
    output logic               Read,
    output logic               MDRin,
    output logic               MDRout,
    output logic               IRin,
    output logic               Yin,
    output logic [15:0]        Rout,
    output logic [15:0]        Rin,
    output logic [3:0]         alu_op,
    output logic               run,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic               stop_q, stop_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_bin, is_un, is_nop, is_halt, is_ill;
    logic       unused_ir;

    assign opcode = ir[31:27];
    assign ra     = ir[26:23];
    assign rb     = ir[22:19];
    assign rc     = ir[18:15];
    assign unused_ir = ^ir[14:0];

`ifndef CU_MEM_WAIT_EN
    // Without wait support the memory handshake has no effect.
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
`endif

    // Opcode class decode.
    always_comb begin
        is_bin  = (opcode[4:3] == 2'b00);
        is_un   = (opcode == 5'b01000) || (opcode == 5'b01001);
        is_nop  = (opcode == 5'b11010);
        is_halt = (opcode == 5'b11011);
        is_ill  = !(is_bin || is_un || is_nop || is_halt);
    end

    // State, stop flag and retired-instruction counter registers.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            stop_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
            count_q <= count_d;
        end
    end

    // Next-state, stop-pending and counter logic.
    always_comb begin
        state_d = state_q;
        stop_d  = stop_q;
        count_d = count_q;
        // A stop arriving in a running cycle is latched; idle/halt ignore it.
        if (stop && state_q != S_IDLE && state_q != S_HALT) begin
            stop_d = 1'b1;
        end
        unique case (state_q)
            S_IDLE: if (start) state_d = S_T0;
            S_T0:   state_d = S_T1;
`ifdef CU_MEM_WAIT_EN
            S_T1:   if (mem_ready) state_d = S_T2;
`else
            S_T1:   state_d = S_T2;
`endif
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (is_bin || is_un) begin
                    state_d = S_T4;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = stop_d ? S_IDLE : S_T0;
                    if (is_nop) count_d = count_q + 1'b1;
                end
            end
            S_T4:   state_d = S_T5;
            S_T5: begin
                state_d = stop_d ? S_IDLE : S_T0;
                count_d = count_q + 1'b1;
            end
            S_HALT: if (start) state_d = S_T0;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) stop_d = 1'b0;
    end

    // Moore output decode from state register and IR fields.
    always_comb begin
        PCout   = 1'b0;
        PCin    = 1'b0;
        IncPc   = 1'b0;
        MARin   = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        Read    = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Rout    = 16'h0000;
        Rin     = 16'h0000;
        alu_op  = 4'h0;
        run     = 1'b0;
        illegal = 1'b0;
        unique case (state_q)
            S_T0: begin
                run   = 1'b1;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPc = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                run = 1'b1;
                if (is_bin) begin
                    Rout = 16'h0001 << rb;
                    Yin  = 1'b1;
                end
                illegal = is_ill;
            end
            S_T4: begin
                run = 1'b1;
                Zin = 1'b1;
                if (is_bin) begin
                    Rout   = 16'h0001 << rc;
                    alu_op = {1'b0, opcode[2:0]};
                end else begin
                    Rout   = 16'h0001 << rb;
                    alu_op = {3'b100, opcode[0]};
                end
            end
            S_T5: begin
                run     = 1'b1;
                Zlowout = 1'b1;
                Rin     = 16'h0001 << ra;
            end
            default: ;
        endcase
    end

    assign instr_count = count_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit.
// Checks fetch/execute strobes, stop, halt, illegal, reset and memory wait.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mem_ready = 1'b1;
    logic [31:0] ir = 32'h0;
    logic PCout, PCin, IncPc, MARin, Zin, Zlowout, Read, MDRin;
    logic MDRout, IRin, Yin, run, illegal;
    logic [15:0] Rout, Rin;
    logic [3:0]  alu_op;
    logic [15:0] instr_count;

    int tests = 0;
    int fails = 0;

    localparam logic [10:0] ST0  = 11'b10111000000;
    localparam logic [10:0] ST1  = 11'b01000111000;
    localparam logic [10:0] ST2  = 11'b00000000110;
    localparam logic [10:0] SYIN = 11'b00000000001;
    localparam logic [10:0] SZIN = 11'b00001000000;
    localparam logic [10:0] SZLO = 11'b00000100000;
    localparam logic [10:0] SNO  = 11'b00000000000;

    control_unit #(.COUNT_W(16)) dut (
        .clock(clock), .clear(clear), .start(start), .stop(stop),
        .mem_ready(mem_ready), .ir(ir),
        .PCout(PCout), .PCin(PCin), .IncPc(IncPc), .MARin(MARin),
        .Zin(Zin), .Zlowout(Zlowout), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .Rout(Rout), .Rin(Rin), .alu_op(alu_op), .run(run),
        .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    logic [48:0] obs;
    assign obs = {PCout, PCin, IncPc, MARin, Zin, Zlowout, Read, MDRin,
                  MDRout, IRin, Yin, Rout, Rin, alu_op, run, illegal};

    function automatic logic [48:0] mk(input logic [10:0] s,
                                       input logic [15:0] ro,
                                       input logic [15:0] ri,
                                       input logic [3:0] a,
                                       input logic r,
                                       input logic il);
        return {s, ro, ri, a, r, il};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        step();
        step();
        tests++;
        if (obs !== 49'h0 || instr_count !== 16'h0) begin
            fails++;
            $display("FAIL reset_hold: outputs %h count %h, required 0 0",
                     obs, instr_count);
        end
        clear = 1'b1;
        step();
        tests++;
        if (obs !== 49'h0 || instr_count !== 16'h0) begin
            fails++;
            $display("FAIL reset_idle: outputs %h count %h, required 0 0",
                     obs, instr_count);
        end
    endtask

    task automatic test_and();
        logic [48:0] exp [6];
        exp[0] = mk(ST0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        exp[1] = mk(ST1, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        exp[2] = mk(ST2, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        exp[3] = mk(SYIN, 16'h0004, 16'h0, 4'h0, 1'b1, 1'b0);
        exp[4] = mk(SZIN, 16'h0008, 16'h0, 4'h2, 1'b1, 1'b0);
        exp[5] = mk(SZLO, 16'h0, 16'h0002, 4'h0, 1'b1, 1'b0);
        ir = 32'h10918000;
        mem_ready = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            start = 1'b0;
            stop = (i == 3);
            tests++;
            if (obs !== exp[i]) begin
                fails++;
                $display("FAIL and_T%0d: got %h required %h", i, obs, exp[i]);
            end
        end
        stop = 1'b0;
        step();
        tests++;
        if (obs !== 49'h0 || instr_count !== 16'd1) begin
            fails++;
            $display("FAIL and_retire: outputs %h count %0d, required 0 1",
                     obs, instr_count);
        end
    endtask

    task automatic test_neg_stop();
        logic [48:0] exp [6];
        exp[0] = mk(ST0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        exp[1] = mk(ST1, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        exp[2] = mk(ST2, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        exp[3] = mk(SNO, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        exp[4] = mk(SZIN, 16'h0040, 16'h0, 4'h8, 1'b1, 1'b0);
        exp[5] = mk(SZLO, 16'h0, 16'h0020, 4'h0, 1'b1, 1'b0);
        ir = 32'h42B00000;
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            start = 1'b0;
            stop = (i == 2);
            tests++;
            if (obs !== exp[i]) begin
                fails++;
                $display("FAIL neg_T%0d: got %h required %h", i, obs, exp[i]);
            end
        end
        stop = 1'b0;
        step();
        tests++;
        if (obs !== 49'h0 || instr_count !== 16'd2) begin
            fails++;
            $display("FAIL neg_stop_idle: outputs %h count %0d, required 0 2",
                     obs, instr_count);
        end
    endtask

    task automatic test_halt_nop();
        ir = 32'hD8000000;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            start = 1'b0;
        end
        tests++;
        if (obs !== mk(SNO, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0)) begin
            fails++;
            $display("FAIL halt_T3: got %h required run only", obs);
        end
        step();
        step();
        tests++;
        if (obs !== 49'h0 || instr_count !== 16'd2) begin
            fails++;
            $display("FAIL halt_state: outputs %h count %0d, required 0 2",
                     obs, instr_count);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        ir = 32'hD0000000;
        stop = 1'b1;
        tests++;
        if (obs !== mk(ST0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0)) begin
            fails++;
            $display("FAIL halt_restart: got %h required T0 strobes", obs);
        end
        step();
        stop = 1'b0;
        step();
        step();
        tests++;
        if (obs !== mk(SNO, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0)) begin
            fails++;
            $display("FAIL nop_T3: got %h required run only", obs);
        end
        step();
        tests++;
        if (obs !== 49'h0 || instr_count !== 16'd3) begin
            fails++;
            $display("FAIL nop_retire: outputs %h count %0d, required 0 3",
                     obs, instr_count);
        end
    endtask

    task automatic test_illegal();
        ir = 32'hF8000000;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        tests++;
        if (obs !== mk(SNO, 16'h0, 16'h0, 4'h0, 1'b1, 1'b1)) begin
            fails++;
            $display("FAIL illegal_T3: got %h required run+illegal", obs);
        end
        step();
        tests++;
        if (obs !== 49'h0 || instr_count !== 16'd3) begin
            fails++;
            $display("FAIL illegal_after: outputs %h count %0d, required 0 3",
                     obs, instr_count);
        end
    endtask

    task automatic test_mem_wait_reset();
        ir = 32'h10918000;
        mem_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
`ifdef CU_MEM_WAIT_EN
        for (int i = 0; i < 4; i++) begin
            step();
            mem_ready = (i == 3);
            tests++;
            if (obs !== mk(ST1, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0)) begin
                fails++;
                $display("FAIL memwait_T1_%0d: got %h required T1", i, obs);
            end
        end
`else
        step();
`endif
        step();
        mem_ready = 1'b1;
        tests++;
        if (obs !== mk(ST2, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0)) begin
            fails++;
            $display("FAIL memwait_T2: got %h required T2 strobes", obs);
        end
        step();
        step();
        tests++;
        if (obs !== mk(SZIN, 16'h0008, 16'h0, 4'h2, 1'b1, 1'b0)) begin
            fails++;
            $display("FAIL pre_reset_T4: got %h required T4", obs);
        end
        clear = 1'b0;
        #1;
        tests++;
        if (obs !== 49'h0 || instr_count !== 16'h0) begin
            fails++;
            $display("FAIL async_clear: outputs %h count %h, required 0 0",
                     obs, instr_count);
        end
        step();
        clear = 1'b1;
        step();
        step();
        tests++;
        if (obs !== 49'h0 || instr_count !== 16'h0) begin
            fails++;
            $display("FAIL post_clear_idle: outputs %h count %h, required 0 0",
                     obs, instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_and();
        test_neg_stop();
        test_halt_nop();
        test_illegal();
        test_mem_wait_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Moore sequencer that sits directly upstream of `datapath` and drives its register-transfer strobes. Each instruction runs the T0–T5 fetch/execute sequence for single-cycle ALU register instructions. It reads the instruction word back from the datapath IR, waits on memory during fetch, and supports start, stop and halt.

## Interface
- `COUNT_W`, 16, width of retired-instruction counter
- `clock`  in  1  system clock, rising edge
- `clear`  in  1  asynchronous, active-low reset
- `start`  in  1  level; leave IDLE/HALT and begin fetch
- `stop`  in  1  one-cycle pulse; request return to IDLE at next instruction boundary
- `mem_ready`  in  1  memory read data valid on `Mdatain`
- `ir`  in  32  datapath IR contents
- `PCout`, `PCin`, `IncPc`, `MARin`, `Zin`, `Zlowout`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin`  out  1 each  datapath strobes
- `Rout`  out  16  one-hot register-file output select
- `Rin`  out  16  one-hot register-file load select
- `alu_op`  out  4  ALU function
- `run`  out  1  high in T0–T5
- `illegal`  out  1  one-cycle pulse on undefined opcode
- `instr_count`  out  COUNT_W  retired-instruction count

## Operation
- Fields: opcode `ir[31:27]`, ra `ir[26:23]`, rb `ir[22:19]`, rc `ir[18:15]`.
- Binary opcodes and `alu_op`: ADD 00000→0, SUB 00001→1, AND 00010→2, OR 00011→3, SHR 00100→4, SHL 00101→5, ROR 00110→6, ROL 00111→7.
- Unary opcodes and `alu_op`: NEG 01000→8, NOT 01001→9.
- Control opcodes: NOP 11010, HALT 11011. All other opcodes are illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT. All outputs are decoded from the state register and `ir`; outputs not listed for a state are 0.
- IDLE: `start`=1 goes to T0.
- T0: `PCout`, `MARin`, `IncPc`, `Zin`. Goes to T1.
- T1: `Zlowout`, `PCin`, `Read`, `MDRin`. Goes to T2 when `mem_ready`=1.
- T2: `MDRout`, `IRin`. Goes to T3.
- T3 decodes `ir`:
  - binary: `Rout`=1<<rb, `Yin`; go to T4.
  - unary: no strobes; go to T4.
  - NOP: go to the boundary check.
  - illegal: `illegal`=1; go to the boundary check.
  - HALT: go to HALT.
- T4 binary: `Rout`=1<<rc, `alu_op`, `Zin`. T4 unary: `Rout`=1<<rb, `alu_op`, `Zin`. Goes to T5.
- T5: `Zlowout`, `Rin`=1<<ra. Goes to the boundary check.
- Boundary check (end of T5, NOP or illegal): go to IDLE if a stop is pending, else T0.
- HALT: `run`=0. `start`=1 goes to T0.
- Stop-pending flag: set by `stop`, cleared on entry to IDLE. `stop` while idle or halted is ignored and does not set the flag.
- `instr_count` increments on leaving T5 and on NOP completion; illegal and HALT are not counted. Wraps modulo 2^COUNT_W.
- `alu_op` is 0 outside T4.

## Timing
- `clear`=0 asynchronously forces IDLE, clears the stop flag, and zeroes `instr_count`. Every output reads 0 while `clear` is low. This applies at any time, including mid-instruction; the aborted instruction is not counted.
- State and counter update on the rising edge of `clock`. Outputs are valid after the state changes and stable for the whole cycle, so the datapath captures them on the next edge.
- Minimum latency is 6 cycles per ALU instruction and 4 per NOP.
- `ir` must be stable from the T2→T3 edge through T5.
- `stop` and `mem_ready` arriving in the same cycle are both honoured.
- `start` held high in IDLE is level-sensitive: the next instruction starts immediately.

## Configuration
- `CU_MEM_WAIT_EN` defined: T1 holds until `mem_ready`=1, with `Read` and `MDRin` held for the whole wait.
- Not defined: `mem_ready` is ignored and T1 always lasts exactly one cycle.

## Test plan
- Reset: `clear`=0 in the middle of T4 → all outputs 0 immediately; after release, state IDLE and `instr_count`=0.
- AND R1,R2,R3: `ir`=32'h10918000 with `mem_ready`=1 → required outputs:
  - T3: `Rout`=16'h0004, `Yin`=1
  - T4: `Rout`=16'h0008, `alu_op`=2, `Zin`=1
  - T5: `Rin`=16'h0002, `Zlowout`=1
  - after retirement: `instr_count`=1
- Memory wait (macro defined): `mem_ready` low for 3 cycles → T1 lasts 4 cycles with `Read`=`MDRin`=1 throughout; T2 follows.
- NEG R5,R6: `ir`=32'h42B00000 → T3 all strobes 0; T4 `Rout`=16'h0040, `alu_op`=8, `Zin`=1; T5 `Rin`=16'h0020.
- HALT then restart: `ir`=32'hD8000000 → HALT state with `run`=0 and `instr_count` unchanged; `start`=1 → T0.
- Stop and illegal:
  - `stop` pulsed during T2 of an ALU instruction → instruction completes through T5, then IDLE.
  - `ir`=32'hF8000000 → one-cycle `illegal` pulse in T3; no count increment.
